// File: rtl/reg_context_switcher_pkg.sv
// Shared definitions for the register-file context switcher.
// Holds the default widths used by the top and the port mux, and the
// sequencer state encoding.
package reg_context_switcher_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_CTX_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SAVE       = 3'd1,
        ST_RESTORE_RD = 3'd2,
        ST_RESTORE_WR = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

endpackage

// File: rtl/reg_context_switcher_rf_port_mux.sv
// Selects who drives the reg_file ports.
// When idle the CPU pipeline ports pass straight through; while a swap is in
// progress the sequencer owns the write port and read port 1, and read port 2
// is parked on x0.
// Ports:
//   busy                     swap in progress (selects sequencer)
//   cpu_*                    CPU pipeline write port and read addresses
//   seq_write/seq_addr/seq_in sequencer write strobe, register index, data
//   rf_*                     reg_file write port and read addresses
module reg_context_switcher_rf_port_mux
    import reg_context_switcher_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  busy,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_inaddress,
    input  logic [DATA_WIDTH-1:0] cpu_in,
    input  logic [ADDR_WIDTH-1:0] cpu_out1address,
    input  logic [ADDR_WIDTH-1:0] cpu_out2address,
    input  logic                  seq_write,
    input  logic [ADDR_WIDTH-1:0] seq_addr,
    input  logic [DATA_WIDTH-1:0] seq_in,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_inaddress,
    output logic [DATA_WIDTH-1:0] rf_in,
    output logic [ADDR_WIDTH-1:0] rf_out1address,
    output logic [ADDR_WIDTH-1:0] rf_out2address
);

    // The sequencer reads and writes through the same register index, so a
    // single seq_addr feeds both the write address and read port 1.
    always_comb begin
        rf_write       = cpu_write;
        rf_inaddress   = cpu_inaddress;
        rf_in          = cpu_in;
        rf_out1address = cpu_out1address;
        rf_out2address = cpu_out2address;
        if (busy) begin
            rf_write       = seq_write;
            rf_inaddress   = seq_addr;
            rf_in          = seq_in;
            rf_out1address = seq_addr;
            rf_out2address = '0;
        end
    end

endmodule

// File: rtl/reg_context_switcher.sv
// Register-file context switcher.
// On an OS context switch this block saves x1..x(NUM_REGS-1) of the resident
// context to an external context memory, then restores the same registers of
// the requested context. busy stalls the pipeline for the whole swap.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   switch_req, new_ctx        swap request and target context (IDLE only)
//   cur_ctx, busy, switch_done resident context, swap in progress, done pulse
//   cpu_*                      CPU pipeline reg_file port requests
//   rf_*                       ports toward reg_file (rf_out1 = read data 1)
//   cm_req/we/addr/wdata       context-memory request, {ctx, reg} address
//   cm_rdata, cm_ack           context-memory read data and handshake
module reg_context_switcher
    import reg_context_switcher_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int CTX_W      = DEF_CTX_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        switch_req,
    input  logic [CTX_W-1:0]            new_ctx,
    output logic [CTX_W-1:0]            cur_ctx,
    output logic                        busy,
    output logic                        switch_done,
    input  logic                        cpu_write,
    input  logic [ADDR_WIDTH-1:0]       cpu_inaddress,
    input  logic [DATA_WIDTH-1:0]       cpu_in,
    input  logic [ADDR_WIDTH-1:0]       cpu_out1address,
    input  logic [ADDR_WIDTH-1:0]       cpu_out2address,
    output logic                        rf_write,
    output logic [ADDR_WIDTH-1:0]       rf_inaddress,
    output logic [DATA_WIDTH-1:0]       rf_in,
    output logic [ADDR_WIDTH-1:0]       rf_out1address,
    output logic [ADDR_WIDTH-1:0]       rf_out2address,
    input  logic [DATA_WIDTH-1:0]       rf_out1,
    output logic                        cm_req,
    output logic                        cm_we,
    output logic [CTX_W+ADDR_WIDTH-1:0] cm_addr,
    output logic [DATA_WIDTH-1:0]       cm_wdata,
    input  logic [DATA_WIDTH-1:0]       cm_rdata,
    input  logic                        cm_ack
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [CTX_W-1:0]      tgt_q, tgt_d;
    logic [CTX_W-1:0]      cur_ctx_q, cur_ctx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  seq_write;

    assign busy     = (state_q != ST_IDLE);
    assign cur_ctx  = cur_ctx_q;
    assign cm_wdata = rf_out1;

    // Sequencer state, register index, target context, restore data and
    // the resident context ID. A mid-swap reset abandons the swap outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= FIRST_IDX;
            tgt_q     <= '0;
            cur_ctx_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tgt_q     <= tgt_d;
            cur_ctx_q <= cur_ctx_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state and sequencer outputs. The context-memory request is a pure
    // function of state so address and write data stay put while the memory
    // withholds its ACK. idx is reloaded to 1 at each phase change and is
    // never allowed to wrap past the last register.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tgt_d       = tgt_q;
        cur_ctx_d   = cur_ctx_q;
        rdata_d     = rdata_q;
        cm_req      = 1'b0;
        cm_we       = 1'b0;
        cm_addr     = {cur_ctx_q, idx_q};
        seq_write   = 1'b0;
        switch_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (switch_req) begin
                    tgt_d = new_ctx;
                    if (new_ctx != cur_ctx_q) begin
                        state_d = ST_SAVE;
                        idx_d   = FIRST_IDX;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SAVE: begin
                cm_req  = 1'b1;
                cm_we   = 1'b1;
                cm_addr = {cur_ctx_q, idx_q};
                if (cm_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RESTORE_RD;
                        idx_d   = FIRST_IDX;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_RESTORE_RD: begin
                cm_req  = 1'b1;
                cm_addr = {tgt_q, idx_q};
                if (cm_ack) begin
                    rdata_d = cm_rdata;
                    state_d = ST_RESTORE_WR;
                end
            end
            ST_RESTORE_WR: begin
                seq_write = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = ST_RESTORE_RD;
                end
            end
            ST_DONE: begin
                cur_ctx_d   = tgt_q;
                switch_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    reg_context_switcher_rf_port_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rf_port_mux (
        .busy            (busy),
        .cpu_write       (cpu_write),
        .cpu_inaddress   (cpu_inaddress),
        .cpu_in          (cpu_in),
        .cpu_out1address (cpu_out1address),
        .cpu_out2address (cpu_out2address),
        .seq_write       (seq_write),
        .seq_addr        (idx_q),
        .seq_in          (rdata_q),
        .rf_write        (rf_write),
        .rf_inaddress    (rf_inaddress),
        .rf_in           (rf_in),
        .rf_out1address  (rf_out1address),
        .rf_out2address  (rf_out2address)
    );

endmodule

// File: tb/tb_reg_context_switcher.sv
// Bench for reg_context_switcher: pairs the DUT with a behavioural reg_file
// and a context memory whose ACK arrives after ack_delay extra wait cycles,
// and checks everything against a context-level model (resident register
// array plus a per-context backing store).
module tb_reg_context_switcher;

    localparam int NREG = 32;
    localparam int NCTX = 4;

    logic        clk;
    logic        rst_n;
    logic        switch_req;
    logic [1:0]  new_ctx;
    logic [1:0]  cur_ctx;
    logic        busy;
    logic        switch_done;
    logic        cpu_write;
    logic [4:0]  cpu_inaddress;
    logic [31:0] cpu_in;
    logic [4:0]  cpu_out1address;
    logic [4:0]  cpu_out2address;
    logic        rf_write;
    logic [4:0]  rf_inaddress;
    logic [31:0] rf_in;
    logic [4:0]  rf_out1address;
    logic [4:0]  rf_out2address;
    logic [31:0] rf_out1;
    logic        cm_req;
    logic        cm_we;
    logic [6:0]  cm_addr;
    logic [31:0] cm_wdata;
    logic [31:0] cm_rdata;
    logic        cm_ack;

    logic [31:0] rf_mem [NREG];
    logic [31:0] cm_mem [NCTX*NREG];
    int          ack_delay;
    int          wait_cnt;
    logic        pre_we;
    logic [6:0]  pre_addr;
    logic [31:0] pre_data;

    logic [31:0] model_res [NREG];
    logic [31:0] model_mem [NCTX*NREG];
    logic [1:0]  model_cur;

    int checks;
    int failures;

    int busy_cnt;
    int done_cnt;
    int req_cnt;
    int stray_cnt;
    int stab_err;
    int wait_seen;
    logic        prev_wait;
    logic [6:0]  prev_addr;
    logic [31:0] prev_wdata;
    logic        prev_we;

    reg_context_switcher dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .switch_req      (switch_req),
        .new_ctx         (new_ctx),
        .cur_ctx         (cur_ctx),
        .busy            (busy),
        .switch_done     (switch_done),
        .cpu_write       (cpu_write),
        .cpu_inaddress   (cpu_inaddress),
        .cpu_in          (cpu_in),
        .cpu_out1address (cpu_out1address),
        .cpu_out2address (cpu_out2address),
        .rf_write        (rf_write),
        .rf_inaddress    (rf_inaddress),
        .rf_in           (rf_in),
        .rf_out1address  (rf_out1address),
        .rf_out2address  (rf_out2address),
        .rf_out1         (rf_out1),
        .cm_req          (cm_req),
        .cm_we           (cm_we),
        .cm_addr         (cm_addr),
        .cm_wdata        (cm_wdata),
        .cm_rdata        (cm_rdata),
        .cm_ack          (cm_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reg_file: x0 reads as zero, combinational read, write at the clock edge
    assign rf_out1 = (rf_out1address == 5'd0) ? 32'd0 : rf_mem[rf_out1address];

    always @(posedge clk) begin
        if (rf_write && rf_inaddress != 5'd0) rf_mem[rf_inaddress] <= rf_in;
    end

    // context memory: ACK after ack_delay wait cycles, read data valid with ACK
    assign cm_ack   = cm_req && (wait_cnt == ack_delay);
    assign cm_rdata = cm_mem[cm_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (cm_req && !cm_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (pre_we) cm_mem[pre_addr] <= pre_data;
        else if (cm_req && cm_ack && cm_we) cm_mem[cm_addr] <= cm_wdata;
    end

    // running event counters and handshake-stability monitor
    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (switch_done) done_cnt <= done_cnt + 1;
        if (cm_req) req_cnt <= req_cnt + 1;
        if (cm_req && !busy) stray_cnt <= stray_cnt + 1;
        if (prev_wait && cm_req) begin
            wait_seen <= wait_seen + 1;
            if (cm_addr != prev_addr || cm_wdata != prev_wdata || cm_we != prev_we)
                stab_err <= stab_err + 1;
        end
        prev_wait  <= cm_req && !cm_ack && rst_n;
        prev_addr  <= cm_addr;
        prev_wdata <= cm_wdata;
        prev_we    <= cm_we;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic cpu_write_reg(input int r, input logic [31:0] v);
        cpu_write     = 1'b1;
        cpu_inaddress = 5'(r);
        cpu_in        = v;
        tick();
        cpu_write     = 1'b0;
        if (r != 0) model_res[r] = v;
    endtask

    task automatic verify_all(input string tag);
        check_output({tag, "_cur_ctx"}, 64'(cur_ctx), 64'(model_cur));
        check_output({tag, "_done_low"}, 64'(switch_done), 64'd0);
        for (int r = 1; r < NREG; r++)
            check_output($sformatf("%s_rf_x%0d", tag, r), 64'(rf_mem[r]), 64'(model_res[r]));
        for (int a = 0; a < NCTX*NREG; a++)
            if (a % NREG != 0)
                check_output($sformatf("%s_cm_%0d_%0d", tag, a / NREG, a % NREG),
                             64'(cm_mem[a]), 64'(model_mem[a]));
    endtask

    // one complete swap request with optional mid-swap CPU write and second request
    task automatic do_swap(input logic [1:0] ctx, input int delay, input bit interfere, input string tag);
        int  b0, d0, c0, cyc, exp_busy, exp_req;
        bit  same;
        same      = (ctx == model_cur);
        exp_busy  = same ? 1 : (NREG-1)*(1+delay) + (NREG-1)*(2+delay) + 1;
        exp_req   = same ? 0 : 2*(NREG-1)*(1+delay);
        ack_delay = delay;
        new_ctx   = ctx;
        switch_req = 1'b1;
        b0 = busy_cnt; d0 = done_cnt; c0 = req_cnt;
        tick();
        switch_req = 1'b0;
        check_output({tag, "_busy_start"}, 64'(busy), 64'd1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            if (interfere && cyc == 10) begin
                cpu_write       = 1'b1;
                cpu_inaddress   = 5'd1;
                cpu_in          = 32'hDEAD;
                cpu_out2address = 5'd7;
                switch_req      = 1'b1;
                new_ctx         = ctx + 2'd1;
                #1;
                check_output({tag, "_busy_rf_write"}, 64'(rf_write), 64'd0);
                check_output({tag, "_busy_out2"}, 64'(rf_out2address), 64'd0);
            end
            tick();
            cpu_write  = 1'b0;
            switch_req = 1'b0;
            new_ctx    = ctx;
            cyc++;
        end
        check_output({tag, "_finished"}, 64'(busy), 64'd0);
        check_output({tag, "_busy_cycles"}, 64'(busy_cnt - b0), 64'(exp_busy));
        check_output({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check_output({tag, "_cm_req_cycles"}, 64'(req_cnt - c0), 64'(exp_req));
        if (!same) begin
            for (int r = 1; r < NREG; r++) begin
                model_mem[int'(model_cur)*NREG + r] = model_res[r];
                model_res[r] = model_mem[int'(ctx)*NREG + r];
            end
            model_cur = ctx;
        end
        verify_all(tag);
    endtask

    task automatic reload_regs();
        for (int r = 1; r < NREG; r++) cpu_write_reg(r, $urandom);
    endtask

    initial begin
        checks = 0; failures = 0;
        busy_cnt = 0; done_cnt = 0; req_cnt = 0; stray_cnt = 0; stab_err = 0; wait_seen = 0;
        prev_wait = 1'b0; prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;
        rst_n = 1'b1; switch_req = 1'b0; new_ctx = 2'd0;
        cpu_write = 1'b0; cpu_inaddress = '0; cpu_in = '0;
        cpu_out1address = '0; cpu_out2address = '0;
        ack_delay = 0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        model_cur = 2'd0;

        // reset asserted mid-cycle: outputs must settle at once
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_cur_ctx", 64'(cur_ctx), 64'd0);
        check_output("rst_done", 64'(switch_done), 64'd0);
        check_output("rst_cm_req", 64'(cm_req), 64'd0);
        check_output("rst_cm_we", 64'(cm_we), 64'd0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // CPU pass-through while idle
        cpu_write = 1'b1; cpu_inaddress = 5'd1; cpu_in = 32'd3;
        cpu_out1address = 5'd1; cpu_out2address = 5'd9;
        #1;
        check_output("idle_rf_write", 64'(rf_write), 64'd1);
        check_output("idle_rf_inaddr", 64'(rf_inaddress), 64'd1);
        check_output("idle_rf_in", 64'(rf_in), 64'd3);
        check_output("idle_out1addr", 64'(rf_out1address), 64'd1);
        check_output("idle_out2addr", 64'(rf_out2address), 64'd9);
        tick();
        cpu_write = 1'b0;
        check_output("idle_x1_written", 64'(rf_mem[1]), 64'd3);
        check_output("idle_x1_readback", 64'(rf_out1), 64'd3);

        // context memory contents: ctx1 holds 100+i, the others random
        for (int a = 0; a < NCTX*NREG; a++) begin
            model_mem[a] = (a / NREG == 1) ? 32'(100 + a % NREG) : $urandom;
            pre_we = 1'b1; pre_addr = 7'(a); pre_data = model_mem[a];
            tick();
        end
        pre_we = 1'b0;
        for (int r = 1; r < NREG; r++) cpu_write_reg(r, 32'(r));

        do_swap(2'd1, 0, 1'b0, "zw");
        check_output("zw_x5", 64'(rf_mem[5]), 64'd105);
        check_output("zw_saved_x7", 64'(cm_mem[7]), 64'd7);

        do_swap(2'd2, 1, 1'b0, "d1");
        do_swap(2'd2, 0, 1'b0, "same");
        do_swap(2'd3, 2, 1'b1, "intf");
        check_output("intf_x1", 64'(rf_mem[1]), 64'(model_mem[3*NREG + 1]));

        // reset during cycle 40 of a 3 -> 0 swap; the save phase is complete by then
        ack_delay = 0; new_ctx = 2'd0; switch_req = 1'b1;
        tick();
        switch_req = 1'b0;
        for (int k = 1; k < 40; k++) tick();
        check_output("abort_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_cur_ctx", 64'(cur_ctx), 64'd0);
        check_output("abort_cm_req", 64'(cm_req), 64'd0);
        check_output("abort_done", 64'(switch_done), 64'd0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int r = 1; r < NREG; r++) model_mem[int'(model_cur)*NREG + r] = model_res[r];
        model_cur = 2'd0;
        reload_regs();
        verify_all("abort");

        // randomized swaps with idle CPU traffic in between
        for (int n = 0; n < 6; n++) begin
            logic [1:0] c;
            int         d;
            int         r;
            c = 2'($urandom_range(0, 3));
            d = $urandom_range(0, 2);
            r = $urandom_range(1, NREG-1);
            cpu_write_reg(r, $urandom);
            cpu_out1address = 5'(r);
            #1;
            check_output($sformatf("rnd%0d_read", n), 64'(rf_out1), 64'(model_res[r]));
            do_swap(c, d, (c != model_cur) && ($urandom_range(0, 1) == 1), $sformatf("rnd%0d", n));
        end

        check_output("cm_stable_while_waiting", 64'(stab_err), 64'd0);
        check_output("cm_req_only_when_busy", 64'(stray_cnt), 64'd0);
        check_output("ack_waits_exercised", 64'(wait_seen > 0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
